prog_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of `cpuCore`'s debug instruction-write port. It receives a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes each one to instruction memory through `dbg_wr_en`/`dbg_addr`/`dbg_instr`. While loading it holds the core in reset. After the last word is written it releases the core's reset so execution starts.

---
 rtl/prog_loader.sv | 141 ++++++++++++++
 tb/tb_prog_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// prog_loader: length-prefixed little-endian byte stream -> core instruction
// memory writes; holds the core in reset until the last word lands.  Rev 1.0
// ============================================================================
module prog_loader #(
  parameter int XLEN      = 32,
  parameter int BASE_ADDR = 4,
  parameter int MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  logic            load_req,
  output logic            dbg_wr_en,
  output logic [XLEN-1:0] dbg_addr,
  output logic [XLEN-1:0] dbg_instr,
  output logic            cpu_rst,
  output logic            done,
  output logic            err
);

  localparam int              RW     = $clog2(MAX_WORDS + 1);
  localparam logic [XLEN-1:0] C_BASE = XLEN'(BASE_ADDR);
  localparam logic [XLEN-1:0] C_MAXW = XLEN'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  // Holds the first three bytes of either the count or a word; the fourth
  // byte is taken straight from rx_data when the value completes.
  logic [XLEN-9:0] shift_q, shift_d;
  logic [RW-1:0]   remain_q, remain_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] dbg_addr_q, dbg_addr_d;
  logic [XLEN-1:0] dbg_instr_q, dbg_instr_d;
  logic [XLEN-1:0] w_full;
  logic            w_ready;
  logic            w_accept;
  logic            w_last_byte;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    remain_d    = remain_q;
    addr_d      = addr_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_instr_d = dbg_instr_q;

    w_ready     = (state_q == S_COUNT) || (state_q == S_DATA);
    w_accept    = rx_valid && w_ready;
    w_last_byte = w_accept && (byte_cnt_q == 2'd3);
    w_full      = {rx_data, shift_q};

    if (w_accept) begin
      shift_d    = w_full[XLEN-1:8];
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        byte_cnt_d = 2'd0;
        addr_d     = C_BASE;
        state_d    = S_COUNT;
      end
      S_COUNT: begin
        if (w_last_byte) begin
          if (w_full == '0) begin
            state_d = S_RUN;
          end else if (w_full > C_MAXW) begin
            state_d = S_ERROR;
          end else begin
            state_d  = S_DATA;
            remain_d = w_full[RW-1:0];
          end
        end
      end
      S_DATA: begin
        // Capture address and data here so both outputs hold after the write.
        if (w_last_byte) begin
          state_d     = S_WRITE;
          dbg_addr_d  = addr_q;
          dbg_instr_d = w_full;
        end
      end
      S_WRITE: begin
        addr_d   = addr_q + XLEN'(4);
        remain_d = remain_q - RW'(1);
        state_d  = (remain_q == RW'(1)) ? S_RUN : S_DATA;
      end
      S_RUN: begin
        if (load_req) state_d = S_IDLE;
      end
      S_ERROR: begin
        if (load_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      shift_q     <= '0;
      remain_q    <= '0;
      addr_q      <= C_BASE;
      dbg_addr_q  <= C_BASE;
      dbg_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      remain_q    <= remain_d;
      addr_q      <= addr_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_instr_q <= dbg_instr_d;
    end
  end

  assign rx_ready  = w_ready;
  assign dbg_wr_en = (state_q == S_WRITE);
  assign dbg_addr  = dbg_addr_q;
  assign dbg_instr = dbg_instr_q;
  assign done      = (state_q == S_RUN);
  assign cpu_rst   = (state_q != S_RUN);
  assign err       = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// tb_prog_loader: directed byte streams checked against a stream-level model
// of the expected instruction writes, plus literal release/handshake checks.
module tb_prog_loader;

  localparam int BASE = 4;
  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        load_req = 1'b0;
  logic        dbg_wr_en;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_instr;
  logic        cpu_rst;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  prog_loader #(.XLEN(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .load_req(load_req),
    .dbg_wr_en(dbg_wr_en), .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        log_q[$];
  wr_t        mon_e;
  logic [7:0] st[$];
  int         n_pass = 0;
  int         n_checks = 0;
  logic       prev_wr = 1'b0;
  bit         mon_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endfunction

  // Stream model: word i of an accepted count lands at BASE + 4*i, provided
  // all four of its bytes are among the first nsend bytes actually sent.
  task automatic expect_stream(input logic [7:0] s[$], input int nsend);
    logic [31:0] n;
    if (nsend < 4) return;
    n = {s[3], s[2], s[1], s[0]};
    if (n > 32'(MAXW)) return;
    for (int i = 0; i < int'(n); i++)
      if (8 + 4 * i <= nsend)
        exp_q.push_back({32'(BASE + 4 * i), {s[7+4*i], s[6+4*i], s[5+4*i], s[4+4*i]}});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rx_valid stays high; the byte only advances once it has been accepted.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!rx_ready) chk1("byte_accept_timeout", rx_ready, 1'b1);
    tick();
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int nsend);
    expect_stream(s, nsend);
    for (int i = 0; i < nsend; i++) send_byte(s[i]);
    rx_valid = 1'b0;
  endtask

  task automatic reload();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk1("reload_cpu_rst", cpu_rst, 1'b1);
    chk1("reload_done", done, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    chk1({tag, "_rx_ready"}, rx_ready, 1'b0);
    chk1({tag, "_wr_en"}, dbg_wr_en, 1'b0);
    chk({tag, "_addr"}, dbg_addr, 32'd4);
    chk({tag, "_instr"}, dbg_instr, 32'd0);
    chk1({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  // Every cycle: writes must match the model queue in order, and the
  // status outputs must stay mutually consistent.
  always @(negedge clk) begin
    if (mon_en) begin
      chk1("ready_during_write", rx_ready & dbg_wr_en, 1'b0);
      chk1("done_with_cpu_rst", done & cpu_rst, 1'b0);
      chk1("err_not_quiet", err & (rx_ready | dbg_wr_en | done | ~cpu_rst), 1'b0);
      if (dbg_wr_en) begin
        chk1("strobe_longer_than_one_cycle", prev_wr, 1'b0);
        if (exp_q.size() == 0) begin
          chk1("unexpected_write", dbg_wr_en, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", dbg_addr, mon_e.addr);
          chk("write_data", dbg_instr, mon_e.data);
        end
        log_q.push_back({dbg_addr, dbg_instr});
      end
      prev_wr <= dbg_wr_en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    tick();
    tick();
    check_reset("reset");
    mon_en = 1'b1;
    rst = 1'b1;
    chk1("ready_before_first_edge", rx_ready, 1'b0);
    tick();
    chk1("ready_after_first_edge", rx_ready, 1'b1);

    // Normal two-word load
    log_q.delete();
    st = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h81, 8'h50, 8'hE7, 8'h23, 8'h20, 8'h20, 8'h00};
    send_stream(st, 12);
    chk1("two_last_strobe", dbg_wr_en, 1'b1);
    chk1("two_ready_in_write", rx_ready, 1'b0);
    chk1("two_cpu_rst_in_write", cpu_rst, 1'b1);
    chk1("two_done_in_write", done, 1'b0);
    tick();
    chk1("two_cpu_rst_released", cpu_rst, 1'b0);
    chk1("two_done", done, 1'b1);
    chk1("two_no_strobe", dbg_wr_en, 1'b0);
    chk("two_addr_hold", dbg_addr, 32'd8);
    chk("two_n", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("two_addr0", log_q[0].addr, 32'd4);
      chk("two_data0", log_q[0].data, 32'hE750_8113);
      chk("two_addr1", log_q[1].addr, 32'd8);
      chk("two_data1", log_q[1].data, 32'h0020_2023);
    end

    // Reload from RUN with a one-word stream
    reload();
    log_q.delete();
    st = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_stream(st, 8);
    tick();
    chk1("one_done", done, 1'b1);
    chk("one_n", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) begin
      chk("one_addr", log_q[0].addr, 32'd4);
      chk("one_data", log_q[0].data, 32'h1234_5678);
    end

    // Empty load
    reload();
    log_q.delete();
    st = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(st, 4);
    chk1("empty_cpu_rst", cpu_rst, 1'b0);
    chk1("empty_done", done, 1'b1);
    tick();
    tick();
    chk("empty_no_writes", 32'(log_q.size()), 32'd0);

    // Oversize count, then recovery
    reload();
    log_q.delete();
    st = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_stream(st, 4);
    chk1("over_err", err, 1'b1);
    chk1("over_ready", rx_ready, 1'b0);
    chk1("over_cpu_rst", cpu_rst, 1'b1);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rx_valid = 1'b0;
    chk1("over_err_sticky", err, 1'b1);
    chk1("over_cpu_rst_sticky", cpu_rst, 1'b1);
    chk("over_no_writes", 32'(log_q.size()), 32'd0);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk1("over_err_cleared", err, 1'b0);
    st = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(st, 8);
    tick();
    chk1("over_recover_done", done, 1'b1);
    chk("over_recover_n", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) begin
      chk("over_recover_addr", log_q[0].addr, 32'd4);
      chk("over_recover_data", log_q[0].data, 32'hDDCC_BBAA);
    end

    // Three words with rx_valid held high across every write cycle
    reload();
    log_q.delete();
    st = '{8'h03, 8'h00, 8'h00, 8'h00,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_stream(st, 16);
    tick();
    chk1("bp_done", done, 1'b1);
    chk("bp_n", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("bp_addr2", log_q[2].addr, 32'd12);
      chk("bp_data1", log_q[1].data, 32'h0807_0605);
      chk("bp_data2", log_q[2].data, 32'h0C0B_0A09);
    end

    // Asynchronous reset after six bytes, then a fresh one-word load
    reload();
    log_q.delete();
    st = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(st, 6);
    #2;
    rst = 1'b0;
    #1;
    check_reset("async_reset");
    tick();
    rst = 1'b1;
    st = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stream(st, 8);
    tick();
    chk1("after_reset_done", done, 1'b1);
    chk("after_reset_n", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) begin
      chk("after_reset_addr", log_q[0].addr, 32'd4);
      chk("after_reset_data", log_q[0].data, 32'hDEAD_BEEF);
    end

    tick();
    chk("model_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
